// File: rtl/fetch_redirect_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, instruction size and
// default PC constants used by the redirect unit and its helpers.
package fetch_redirect_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SQUASH = 2'd1,
        ST_TRAP   = 2'd2
    } state_e;

    localparam int unsigned INSTR_BYTES  = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_PC  = 32'h0000_0180;

    // Targets must be word aligned; only the two low address bits matter.
    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_redirect_unit_if.sv
// Redirect/fetch bundle between the EX/MEM register outputs and the fetch unit.
// The pipeline side is the master; the fetch unit is the slave.
interface fetch_redirect_unit_if #(
    parameter int CNT_W = 16
) ();
    logic             stall;
    logic             PCSrc_in;
    logic             JtoPC_in;
    logic [31:0]      branch_addr_in;
    logic [31:0]      jump_addr_in;
    logic [31:0]      PC;
    logic [31:0]      next_PC;
    logic             flush;
    logic             trap;
    logic [CNT_W-1:0] redirect_cnt;

    modport master (
        output stall, PCSrc_in, JtoPC_in, branch_addr_in, jump_addr_in,
        input  PC, next_PC, flush, trap, redirect_cnt
    );

    modport slave (
        input  stall, PCSrc_in, JtoPC_in, branch_addr_in, jump_addr_in,
        output PC, next_PC, flush, trap, redirect_cnt
    );
endinterface

// File: rtl/fetch_redirect_unit_redirect_sel.sv
// Combinational redirect target select: jump wins over taken branch, and the
// chosen target is flagged when it is not word aligned.
module fetch_redirect_unit_redirect_sel
    import fetch_redirect_unit_pkg::*;
(
    input  logic        i_pcsrc,
    input  logic        i_jtopc,
    input  logic [31:0] i_branch_addr,
    input  logic [31:0] i_jump_addr,
    output logic        o_redirect,
    output logic [31:0] o_target,
    output logic        o_misaligned
);
    assign o_redirect   = i_pcsrc | i_jtopc;
    assign o_target     = i_jtopc ? i_jump_addr : i_branch_addr;
    assign o_misaligned = is_misaligned(o_target[1:0]);
endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch-side PC owner: applies EX/MEM redirects, squashes the younger slots for
// FLUSH_DEPTH cycles, traps misaligned targets and counts accepted redirects.
module fetch_redirect_unit
    import fetch_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
    parameter logic [31:0] TRAP_PC     = DEF_TRAP_PC,
    parameter int          FLUSH_DEPTH = 3,
    parameter int          CNT_W       = 16
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    fetch_redirect_unit_if.slave  bus
);
    localparam int          CTR_W    = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
    localparam logic [CTR_W-1:0] CTR_LOAD = CTR_W'(FLUSH_DEPTH - 1);
    localparam logic [31:0] PC_STEP  = 32'(INSTR_BYTES);

    state_e           r_state, w_state_nxt;
    logic [31:0]      r_pc, w_pc_nxt, w_pc_inc;
    logic             r_flush, w_flush_nxt;
    logic             r_trap, w_trap_nxt;
    logic [CTR_W-1:0] r_ctr, w_ctr_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic             w_redirect;
    logic [31:0]      w_target;
    logic             w_misaligned;

    fetch_redirect_unit_redirect_sel u_redirect_sel (
        .i_pcsrc       (bus.PCSrc_in),
        .i_jtopc       (bus.JtoPC_in),
        .i_branch_addr (bus.branch_addr_in),
        .i_jump_addr   (bus.jump_addr_in),
        .o_redirect    (w_redirect),
        .o_target      (w_target),
        .o_misaligned  (w_misaligned)
    );

    assign w_pc_inc = r_pc + PC_STEP;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned (which would infer a latch).
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_flush_nxt = r_flush;
        w_trap_nxt  = 1'b0;
        w_ctr_nxt   = r_ctr;
        w_cnt_nxt   = r_cnt;

        unique case (r_state)
            ST_RUN: begin
                if (w_redirect) begin
                    w_flush_nxt = 1'b1;
                    w_ctr_nxt   = CTR_LOAD;
                    if (w_misaligned) begin
                        w_pc_nxt    = TRAP_PC;
                        w_trap_nxt  = 1'b1;
                        w_state_nxt = ST_TRAP;
                    end else begin
                        w_pc_nxt    = w_target;
                        w_state_nxt = ST_SQUASH;
                        if (!(&r_cnt)) w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else if (!bus.stall) begin
                    w_pc_nxt = w_pc_inc;
                end
            end
            // The trap cycle is the first squash cycle, so both states share
            // the countdown; redirects and stall are ignored while squashing.
            ST_SQUASH, ST_TRAP: begin
                w_pc_nxt = w_pc_inc;
                if (r_ctr == '0) begin
                    w_flush_nxt = 1'b0;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_ctr_nxt   = r_ctr - CTR_W'(1);
                    w_state_nxt = ST_SQUASH;
                end
            end
            default: begin
                w_flush_nxt = 1'b0;
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_flush <= 1'b0;
            r_trap  <= 1'b0;
            r_ctr   <= '0;
            r_cnt   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_flush <= w_flush_nxt;
            r_trap  <= w_trap_nxt;
            r_ctr   <= w_ctr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign bus.PC           = r_pc;
    assign bus.next_PC      = w_pc_inc;
    assign bus.flush        = r_flush;
    assign bus.trap         = r_trap;
    assign bus.redirect_cnt = r_cnt;
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed table-driven bench for fetch_redirect_unit: default instance plus a
// FLUSH_DEPTH=1 / CNT_W=2 instance for the single-cycle squash and saturation.
module tb_fetch_redirect_unit;
    logic CLK = 1'b0;
    logic RSTn;

    always #5 CLK = ~CLK;

    fetch_redirect_unit_if #(.CNT_W(16)) bus0 ();
    fetch_redirect_unit_if #(.CNT_W(2))  bus1 ();

    fetch_redirect_unit #(.FLUSH_DEPTH(3), .CNT_W(16)) dut0 (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus0)
    );

    fetch_redirect_unit #(.FLUSH_DEPTH(1), .CNT_W(2)) dut1 (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus1)
    );

    typedef struct {
        logic        stall;
        logic        pcsrc;
        logic        jtopc;
        logic [31:0] baddr;
        logic [31:0] jaddr;
        logic [31:0] exp_pc;
        logic        exp_flush;
        logic        exp_trap;
        logic [31:0] exp_cnt;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    vec_t v0[27];
    vec_t v1[10];

    function automatic vec_t mk(input logic st, input logic ps, input logic jt,
                                input logic [31:0] ba, input logic [31:0] ja,
                                input logic [31:0] pc, input logic fl,
                                input logic tr, input logic [31:0] cnt);
        vec_t v;
        v.stall = st; v.pcsrc = ps; v.jtopc = jt; v.baddr = ba; v.jaddr = ja;
        v.exp_pc = pc; v.exp_flush = fl; v.exp_trap = tr; v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive0(input vec_t v);
        bus0.stall = v.stall; bus0.PCSrc_in = v.pcsrc; bus0.JtoPC_in = v.jtopc;
        bus0.branch_addr_in = v.baddr; bus0.jump_addr_in = v.jaddr;
    endtask

    task automatic drive1(input vec_t v);
        bus1.stall = v.stall; bus1.PCSrc_in = v.pcsrc; bus1.JtoPC_in = v.jtopc;
        bus1.branch_addr_in = v.baddr; bus1.jump_addr_in = v.jaddr;
    endtask

    task automatic check0(input string tag, input int idx, input vec_t v);
        check({tag, ".PC"},      idx, bus0.PC, v.exp_pc);
        check({tag, ".next_PC"}, idx, bus0.next_PC, v.exp_pc + 32'd4);
        check({tag, ".flush"},   idx, 32'(bus0.flush), 32'(v.exp_flush));
        check({tag, ".trap"},    idx, 32'(bus0.trap), 32'(v.exp_trap));
        check({tag, ".cnt"},     idx, 32'(bus0.redirect_cnt), v.exp_cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t idle;
        idle = mk(0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);

        // Main instance: fetch, stall, branch, ignored redirect, jump priority,
        // misaligned jump/branch, redirect over stall, PC wrap.
        v0[0]  = mk(0, 0, 0, 32'h0,        32'h0,   32'h0000_0004, 0, 0, 0);
        v0[1]  = mk(0, 0, 0, 32'h0,        32'h0,   32'h0000_0008, 0, 0, 0);
        v0[2]  = mk(0, 0, 0, 32'h0,        32'h0,   32'h0000_000C, 0, 0, 0);
        v0[3]  = mk(0, 0, 0, 32'h0,        32'h0,   32'h0000_0010, 0, 0, 0);
        v0[4]  = mk(1, 0, 0, 32'h0,        32'h0,   32'h0000_0010, 0, 0, 0);
        v0[5]  = mk(1, 0, 0, 32'h0,        32'h0,   32'h0000_0010, 0, 0, 0);
        v0[6]  = mk(0, 1, 0, 32'h40,       32'h0,   32'h0000_0040, 1, 0, 1);
        v0[7]  = mk(0, 1, 0, 32'h200,      32'h0,   32'h0000_0044, 1, 0, 1);
        v0[8]  = mk(1, 0, 0, 32'h0,        32'h0,   32'h0000_0048, 1, 0, 1);
        v0[9]  = mk(0, 0, 0, 32'h0,        32'h0,   32'h0000_004C, 0, 0, 1);
        v0[10] = mk(0, 1, 1, 32'h80,       32'h100, 32'h0000_0100, 1, 0, 2);
        v0[11] = mk(0, 0, 0, 32'h0,        32'h0,   32'h0000_0104, 1, 0, 2);
        v0[12] = mk(0, 0, 0, 32'h0,        32'h0,   32'h0000_0108, 1, 0, 2);
        v0[13] = mk(0, 0, 0, 32'h0,        32'h0,   32'h0000_010C, 0, 0, 2);
        v0[14] = mk(0, 0, 1, 32'h0,        32'h102, 32'h0000_0180, 1, 1, 2);
        v0[15] = mk(0, 0, 0, 32'h0,        32'h0,   32'h0000_0184, 1, 0, 2);
        v0[16] = mk(0, 0, 0, 32'h0,        32'h0,   32'h0000_0188, 1, 0, 2);
        v0[17] = mk(0, 0, 0, 32'h0,        32'h0,   32'h0000_018C, 0, 0, 2);
        v0[18] = mk(1, 1, 0, 32'hFFFF_FFF0, 32'h0,  32'hFFFF_FFF0, 1, 0, 3);
        v0[19] = mk(1, 0, 0, 32'h0,        32'h0,   32'hFFFF_FFF4, 1, 0, 3);
        v0[20] = mk(1, 0, 0, 32'h0,        32'h0,   32'hFFFF_FFF8, 1, 0, 3);
        v0[21] = mk(1, 0, 0, 32'h0,        32'h0,   32'hFFFF_FFFC, 0, 0, 3);
        v0[22] = mk(0, 0, 0, 32'h0,        32'h0,   32'h0000_0000, 0, 0, 3);
        v0[23] = mk(0, 1, 0, 32'h41,       32'h0,   32'h0000_0180, 1, 1, 3);
        v0[24] = mk(0, 0, 0, 32'h0,        32'h0,   32'h0000_0184, 1, 0, 3);
        v0[25] = mk(0, 0, 0, 32'h0,        32'h0,   32'h0000_0188, 1, 0, 3);
        v0[26] = mk(0, 0, 0, 32'h0,        32'h0,   32'h0000_018C, 0, 0, 3);

        // FLUSH_DEPTH=1, CNT_W=2 instance: one-cycle squash/trap, saturation at 3.
        v1[0] = mk(0, 1, 0, 32'h20, 32'h0,  32'h0000_0020, 1, 0, 1);
        v1[1] = mk(0, 0, 0, 32'h0,  32'h0,  32'h0000_0024, 0, 0, 1);
        v1[2] = mk(0, 0, 1, 32'h0,  32'h40, 32'h0000_0040, 1, 0, 2);
        v1[3] = mk(0, 0, 0, 32'h0,  32'h0,  32'h0000_0044, 0, 0, 2);
        v1[4] = mk(0, 1, 0, 32'h60, 32'h0,  32'h0000_0060, 1, 0, 3);
        v1[5] = mk(0, 0, 0, 32'h0,  32'h0,  32'h0000_0064, 0, 0, 3);
        v1[6] = mk(0, 1, 0, 32'h80, 32'h0,  32'h0000_0080, 1, 0, 3);
        v1[7] = mk(0, 0, 0, 32'h0,  32'h0,  32'h0000_0084, 0, 0, 3);
        v1[8] = mk(0, 0, 1, 32'h0,  32'h83, 32'h0000_0180, 1, 1, 3);
        v1[9] = mk(0, 0, 0, 32'h0,  32'h0,  32'h0000_0184, 0, 0, 3);

        RSTn = 1'b0;
        drive0(idle);
        drive1(idle);
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        check0("reset", 0, idle);
        check("reset.dut1_pc", 0, bus1.PC, 32'h0);

        for (int i = 0; i < 27; i++) begin
            drive0(v0[i]);
            @(posedge CLK);
            @(negedge CLK);
            check0("main", i, v0[i]);
        end

        // Asynchronous reset in the middle of a squash window.
        drive0(mk(0, 1, 0, 32'h20, 32'h0, 32'h0, 0, 0, 0));
        @(posedge CLK);
        #2;
        check("pre_rst.flush", 0, 32'(bus0.flush), 32'd1);
        drive0(idle);
        RSTn = 1'b0;
        #1;
        check0("async_rst", 0, idle);
        @(negedge CLK);
        RSTn = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check0("post_rst", 0, mk(0, 0, 0, 32'h0, 32'h0, 32'h4, 0, 0, 0));

        // Asynchronous reset during a trap cycle.
        drive0(mk(0, 0, 1, 32'h0, 32'h6, 32'h0, 0, 0, 0));
        @(posedge CLK);
        #2;
        check("pre_rst.trap", 0, 32'(bus0.trap), 32'd1);
        drive0(idle);
        RSTn = 1'b0;
        #1;
        check0("trap_rst", 0, idle);
        @(negedge CLK);
        RSTn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive1(v1[i]);
            @(posedge CLK);
            @(negedge CLK);
            check("fd1.PC",    i, bus1.PC, v1[i].exp_pc);
            check("fd1.flush", i, 32'(bus1.flush), 32'(v1[i].exp_flush));
            check("fd1.trap",  i, 32'(bus1.trap), 32'(v1[i].exp_trap));
            check("fd1.cnt",   i, 32'(bus1.redirect_cnt), v1[i].exp_cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
